// File: rtl/click_pkg.sv
// Shared constants for the click pipeline and its synchronous sink.
package click_pkg;

    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 4;

    // Width needed to hold a token count from 0 up to and including depth.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/click_sync.sv
// Reset-to-0 flop chain that brings the two-phase request into the clock
// domain. Chain length is 2, or 3 when CLICK_SINK_SYNC3_EN is defined.
module click_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

`ifdef CLICK_SINK_SYNC3_EN
    localparam int STAGES = 3;
`else
    localparam int STAGES = 2;
`endif

    logic [STAGES-1:0] sr;

    // Shift the raw request through the chain; sr[0] is the first flop.
    always_ff @(posedge clk) begin
        if (rst) sr <= '0;
        else     sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/click_sink.sv
// Clocked consumer for the click pipeline: synchronizes the two-phase
// request, buffers tokens in a show-ahead FIFO and returns a two-phase
// acknowledge only when a token has actually been stored, so a full FIFO
// stalls the asynchronous side. Optional macro: CLICK_SINK_SYNC3_EN
// (three-flop synchronizer, one extra cycle of request latency).
module click_sink
    import click_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_req,
    input  logic [DW-1:0]             i_data,
    output logic                      o_ack,
    output logic [DW-1:0]             o_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [lvl_w(DEPTH)-1:0]   o_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic                req_s;
    logic                ack_q;
    logic [PW-1:0]       wptr;
    logic [PW-1:0]       rptr;
    logic [LW-1:0]       level;
    logic [DEPTH-1:0][DW-1:0] mem;
    logic                wr_en;
    logic                rd_en;

    click_sync u_sync (
        .clk (i_clk),
        .rst (i_rst),
        .d   (i_req),
        .q   (req_s)
    );

    // Fullness is judged on the registered level, so a pop in the same
    // cycle does not free a slot for a write until the next edge.
    assign wr_en = (req_s != ack_q) && (level < LW'(DEPTH));
    assign rd_en = o_valid && i_ready;

    // FIFO storage, pointers, level and acknowledge toggle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mem   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ack_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wptr] <= i_data;
                wptr      <= wptr + PW'(1);
                ack_q     <= ~ack_q;
            end
            if (rd_en) rptr <= rptr + PW'(1);
            unique case ({wr_en, rd_en})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign o_ack   = ack_q;
    assign o_data  = mem[rptr];
    assign o_valid = (level != '0);
    assign o_level = level;

endmodule
